frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Per-frame game-tick controller for the Flappy Bird core.
- Gates the input sampler's enable once every FRAME_DIV video frames and captures a flap request during that window.
- Triggers the physics/update stage, then checks collision to decide whether to continue or end the game.
- Sits between the VGA timing (vsync), the input sampler (enable/done/pulse outputs) and the game-state update logic.

Parameters:
- FRAME_DIV, 2: game ticks run once every FRAME_DIV rising vsync edges; legal range 1..15.
- SAMPLE_LEN, 4: number of cycles e_inp_o stays high per tick; legal range 2..15.
- TIMEOUT, 255: maximum cycles allowed in SAMPLE or UPDATE before an abort; legal range 2..255.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous reset, active low.
- vsync_i  in  1  vertical sync level; a rising edge marks frame start.
- start_i  in  1  start/restart request pulse (input sampler right_o).
- flap_i  in  1  flap request pulse (input sampler left_o).
- d_inp_i  in  1  input sampler acknowledge (d_inp_o).
- upd_done_i  in  1  update stage finished, one-cycle pulse or level.
- collision_i  in  1  collision flag from the update stage, sampled in CHECK.
- e_inp_o  out  1  input sampler enable.
- e_upd_o  out  1  update start pulse, one cycle.
- flap_o  out  1  latched flap request for the current tick.
- running_o  out  1  game in progress.
- game_over_o  out  1  game ended.
- timeout_err_o  out  1  sticky handshake-timeout flag.
- score_o  out  8  completed ticks, saturating at 255.

Behaviour:
- Clock and reset: single clock domain, one clock; reset is asynchronous and active-low (rst_ni). Reset mid-operation aborts any tick immediately.
- Reset values: state=IDLE; all outputs 0; vsync_q, div_cnt, cyc_cnt, flap latch and score all 0.
- Registered outputs: every output is a flop loaded from next-state decode, so an output changes in the same cycle the state register changes.
- Edge detect: frame_pulse = vsync_i & ~vsync_q, with vsync_q registered every cycle.
- IDLE:
  - e_inp_o=1, running_o=0.
  - start_i=1 -> WAIT_FRAME; clear div_cnt, score and game_over_o.
- WAIT_FRAME:
  - e_inp_o=0, running_o=1.
  - On frame_pulse: if div_cnt==FRAME_DIV-1, set div_cnt=0 and go to SAMPLE; otherwise div_cnt+1.
- SAMPLE:
  - e_inp_o=1; cyc_cnt counts from 0; flap latch |= flap_i.
  - Exit to LATCH when cyc_cnt>=SAMPLE_LEN-1 and d_inp_i=1.
- LATCH:
  - One cycle, e_inp_o=0.
  - flap latch |= flap_i, which catches the sampler's 1-cycle output latency.
  - Go to UPDATE; e_upd_o=1 and flap_o=latch on entry.
- UPDATE:
  - e_upd_o is high only on the entry cycle; flap_o is held.
  - cyc_cnt restarts at 0.
  - upd_done_i=1 -> CHECK. A done pulse on the entry cycle itself is accepted.
- CHECK:
  - One cycle; clear the flap latch and flap_o.
  - collision_i=1 -> OVER.
  - Otherwise score = min(score+1, 255) and go to WAIT_FRAME.
- OVER:
  - game_over_o=1, running_o=0, e_inp_o=1, score held.
  - start_i=1 -> WAIT_FRAME; clear score, div_cnt and game_over_o. timeout_err_o is not cleared.
- Timeout:
  - In SAMPLE or UPDATE, if cyc_cnt reaches TIMEOUT-1 without the exit condition: timeout_err_o<=1 (sticky until reset), then go to OVER.
  - On this abort the flap latch is cleared and e_upd_o is not issued.
- Dropped events:
  - frame_pulse outside WAIT_FRAME is dropped, and div_cnt is unchanged by it.
  - start_i outside IDLE/OVER is ignored.
  - flap_i outside SAMPLE/LATCH is ignored.
- Simultaneous events:
  - frame_pulse and start_i together in IDLE: only the start is taken; that frame_pulse is not counted.
  - collision_i in CHECK has priority over the score increment.
- Width rules:
  - div_cnt and cyc_cnt are 4 and 8 bits.
  - score saturates, never wraps.

Test Plan (FRAME_DIV=2, SAMPLE_LEN=4, TIMEOUT=16):
1. Reset release, then start_i pulse -> running_o=1. Two vsync rising edges -> e_inp_o high for exactly 4 cycles starting the cycle after the 2nd edge is registered, with d_inp_i tied to e_inp_o delayed 1 cycle.
2. flap_i pulse on the cycle after SAMPLE ends (LATCH) -> flap_o=1 with e_upd_o. upd_done_i after 3 cycles, collision_i=0 -> score_o=1 and flap_o=0.
3. Run 300 ticks with no collision -> score_o saturates at 255 and holds.
4. collision_i=1 in CHECK -> game_over_o=1, running_o=0, score_o holds. A start_i pulse then gives score_o=0 and running_o=1.
5. upd_done_i never asserted -> 16 cycles after UPDATE entry, timeout_err_o=1 and game_over_o=1. timeout_err_o persists across restart and clears only on rst_ni low.
6. vsync edges delivered during UPDATE and rst_ni asserted mid-SAMPLE -> dropped edges do not advance div_cnt; asynchronous reset forces all outputs to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame game-tick controller for the Flappy Bird core.
//
// Every FRAME_DIV rising vsync edges it opens a SAMPLE window on the input
// sampler, captures any flap request, fires a one-cycle update start, waits for
// the update stage to finish, then checks collision to continue or end the game.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous reset, active low
//   vsync_i        vertical sync level; rising edge marks a frame start
//   start_i        start/restart request (taken in IDLE or OVER only)
//   flap_i         flap request (taken in SAMPLE or LATCH only)
//   d_inp_i        input sampler acknowledge
//   upd_done_i     update stage finished
//   collision_i    collision flag, sampled in CHECK
//   e_inp_o        input sampler enable
//   e_upd_o        update start pulse (one cycle, on UPDATE entry)
//   flap_o         latched flap request, valid while UPDATE
//   running_o      game in progress
//   game_over_o    game ended
//   timeout_err_o  sticky handshake-timeout flag (cleared only by reset)
//   score_o        completed ticks, saturating at 255
//
// Handshake: the sampler window closes only once SAMPLE_LEN cycles have elapsed
// AND d_inp_i is high in the same cycle; the update stage is done on any cycle
// of UPDATE (including its entry cycle) where upd_done_i is high. Either wait
// is bounded by TIMEOUT cycles, after which the game is forced to OVER.
//
// All outputs are flops loaded from the decode of the next state, so they
// change on the same edge as the state register.
module frame_sequencer #(
  parameter int unsigned FRAME_DIV  = 2,
  parameter int unsigned SAMPLE_LEN = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vsync_i,
  input  logic       start_i,
  input  logic       flap_i,
  input  logic       d_inp_i,
  input  logic       upd_done_i,
  input  logic       collision_i,
  output logic       e_inp_o,
  output logic       e_upd_o,
  output logic       flap_o,
  output logic       running_o,
  output logic       game_over_o,
  output logic       timeout_err_o,
  output logic [7:0] score_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_SAMPLE,
    S_LATCH,
    S_UPDATE,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic [3:0] DIV_LAST    = 4'(FRAME_DIV - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_LEN - 1);
  localparam logic [7:0] CYC_LAST    = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       vsync_q;
  logic [3:0] div_cnt;
  logic [7:0] cyc_cnt;
  logic       flap_lat;

  logic frame_pulse;
  logic start_take;
  logic timeout_hit;
  logic e_inp_d, e_upd_d, flap_d, running_d, game_over_d;

  assign frame_pulse = vsync_i & ~vsync_q;

  // Next-state decode
  always_comb begin
    state_d     = state_q;
    start_take  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        // A frame pulse in the same cycle is not counted: div_cnt only moves in WAIT_FRAME.
        if (start_i) begin
          state_d    = S_WAIT_FRAME;
          start_take = 1'b1;
        end
      end
      S_WAIT_FRAME: begin
        if (frame_pulse && (div_cnt == DIV_LAST)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        // The exit condition wins over a timeout reached in the same cycle.
        if ((cyc_cnt >= SAMPLE_LAST) && d_inp_i) begin
          state_d = S_LATCH;
        end else if (cyc_cnt == CYC_LAST) begin
          state_d     = S_OVER;
          timeout_hit = 1'b1;
        end
      end
      S_LATCH: state_d = S_UPDATE;
      S_UPDATE: begin
        if (upd_done_i) begin
          state_d = S_CHECK;
        end else if (cyc_cnt == CYC_LAST) begin
          state_d     = S_OVER;
          timeout_hit = 1'b1;
        end
      end
      S_CHECK: state_d = collision_i ? S_OVER : S_WAIT_FRAME;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state
  always_comb begin
    e_inp_d     = (state_d == S_IDLE) || (state_d == S_SAMPLE) || (state_d == S_OVER);
    running_d   = (state_d == S_WAIT_FRAME) || (state_d == S_SAMPLE) || (state_d == S_LATCH) ||
                  (state_d == S_UPDATE) || (state_d == S_CHECK);
    game_over_d = (state_d == S_OVER);
    e_upd_d     = (state_d == S_UPDATE) && (state_q == S_LATCH);
    flap_d      = 1'b0;
    if (state_d == S_UPDATE) begin
      // The LATCH cycle still ORs flap_i so a request arriving one cycle late is kept.
      flap_d = (state_q == S_LATCH) ? (flap_lat | flap_i) : flap_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b0;
      div_cnt       <= '0;
      cyc_cnt       <= '0;
      flap_lat      <= 1'b0;
      score_o       <= '0;
      e_inp_o       <= 1'b0;
      e_upd_o       <= 1'b0;
      flap_o        <= 1'b0;
      running_o     <= 1'b0;
      game_over_o   <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_i;
      e_inp_o     <= e_inp_d;
      e_upd_o     <= e_upd_d;
      flap_o      <= flap_d;
      running_o   <= running_d;
      game_over_o <= game_over_d;

      if (timeout_hit) timeout_err_o <= 1'b1;

      if (start_take) begin
        div_cnt <= '0;
      end else if ((state_q == S_WAIT_FRAME) && frame_pulse) begin
        div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      end

      // cyc_cnt is 0 on the first cycle of every state and counts up while it stays.
      if (state_d != state_q) begin
        cyc_cnt <= '0;
      end else if ((state_q == S_SAMPLE) || (state_q == S_UPDATE)) begin
        cyc_cnt <= cyc_cnt + 8'd1;
      end

      if (timeout_hit || (state_q == S_CHECK)) begin
        flap_lat <= 1'b0;
      end else if ((state_q == S_SAMPLE) || (state_q == S_LATCH)) begin
        flap_lat <= flap_lat | flap_i;
      end

      if (start_take) begin
        score_o <= '0;
      end else if ((state_q == S_CHECK) && !collision_i && (score_o != 8'hFF)) begin
        score_o <= score_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer with FRAME_DIV=2, SAMPLE_LEN=4, TIMEOUT=16.
// A phase-level game model predicts every output each cycle; directed
// scenarios add hand-computed literal checks at the interesting points.
module tb_frame_sequencer;

  localparam int FRAME_DIV  = 2;
  localparam int SAMPLE_LEN = 4;
  localparam int TIMEOUT    = 16;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  logic       vsync_i = 1'b0, start_i = 1'b0, flap_i = 1'b0;
  logic       upd_done_i = 1'b0, collision_i = 1'b0;
  logic       d_inp_i;
  logic       e_inp_o, e_upd_o, flap_o, running_o, game_over_o, timeout_err_o;
  logic [7:0] score_o;

  // Sampler acknowledge follows its enable one cycle late (can be switched off).
  logic d_follow = 1'b1;
  logic e_del;
  always @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) e_del <= 1'b0;
    else         e_del <= e_inp_o;
  assign d_inp_i = d_follow & e_del;

  frame_sequencer #(
    .FRAME_DIV (FRAME_DIV),
    .SAMPLE_LEN(SAMPLE_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .vsync_i      (vsync_i),
    .start_i      (start_i),
    .flap_i       (flap_i),
    .d_inp_i      (d_inp_i),
    .upd_done_i   (upd_done_i),
    .collision_i  (collision_i),
    .e_inp_o      (e_inp_o),
    .e_upd_o      (e_upd_o),
    .flap_o       (flap_o),
    .running_o    (running_o),
    .game_over_o  (game_over_o),
    .timeout_err_o(timeout_err_o),
    .score_o      (score_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- game model ----------------
  localparam int M_IDLE = 0, M_WAIT = 1, M_SAMP = 2, M_LAT = 3, M_UPD = 4, M_CHK = 5, M_OVER = 6;

  int m_phase, m_frames, m_cnt, m_score;
  bit m_vs, m_flap, m_terr;
  bit x_e_inp, x_e_upd, x_flap, x_run, x_over;

  always @(posedge clk_i or negedge rst_ni) begin : model
    automatic int ph, nph, frames, score;
    automatic bit flap, abort, fp;
    if (!rst_ni) begin
      m_phase <= M_IDLE; m_frames <= 0; m_cnt <= 0; m_score <= 0;
      m_vs <= 0; m_flap <= 0; m_terr <= 0;
      x_e_inp <= 0; x_e_upd <= 0; x_flap <= 0; x_run <= 0; x_over <= 0;
    end else begin
      ph = m_phase; nph = ph; frames = m_frames; score = m_score;
      flap = m_flap; abort = 0;
      fp = vsync_i && !m_vs;
      case (ph)
        M_IDLE, M_OVER: if (start_i) begin nph = M_WAIT; frames = 0; score = 0; end
        M_WAIT: if (fp) begin
          frames++;
          if (frames == FRAME_DIV) begin frames = 0; nph = M_SAMP; end
        end
        M_SAMP: begin
          flap = flap | flap_i;
          if (m_cnt + 1 >= SAMPLE_LEN && d_inp_i) nph = M_LAT;
          else if (m_cnt + 1 == TIMEOUT) abort = 1;
        end
        M_LAT: begin flap = flap | flap_i; nph = M_UPD; end
        M_UPD: begin
          if (upd_done_i) nph = M_CHK;
          else if (m_cnt + 1 == TIMEOUT) abort = 1;
        end
        M_CHK: begin
          flap = 0;
          if (collision_i) nph = M_OVER;
          else begin nph = M_WAIT; if (score < 255) score++; end
        end
        default: nph = M_IDLE;
      endcase
      if (abort) begin m_terr <= 1; flap = 0; nph = M_OVER; end
      m_phase  <= nph;
      m_frames <= frames;
      m_score  <= score;
      m_flap   <= flap;
      m_vs     <= vsync_i;
      m_cnt    <= (nph == ph) ? m_cnt + 1 : 0;
      x_e_inp  <= (nph == M_IDLE) || (nph == M_SAMP) || (nph == M_OVER);
      x_run    <= (nph inside {M_WAIT, M_SAMP, M_LAT, M_UPD, M_CHK});
      x_over   <= (nph == M_OVER);
      x_e_upd  <= (ph == M_LAT);
      x_flap   <= (nph == M_UPD) ? ((ph == M_LAT) ? flap : x_flap) : 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (rst_ni) begin
      automatic logic [13:0] act = {e_inp_o, e_upd_o, flap_o, running_o, game_over_o,
                                    timeout_err_o, score_o};
      automatic logic [13:0] exp = {x_e_inp, x_e_upd, x_flap, x_run, x_over, m_terr,
                                    8'(m_score)};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle_outputs at %0t: got %h, expected %h", $time, act, exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic vsync_edge();
    vsync_i = 1'b0; step();
    vsync_i = 1'b1; step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1; step(); start_i = 1'b0;
  endtask

  // Drives frames until UPDATE is entered, optionally returns done/collision.
  task automatic run_tick(input bit flap, input bit collide, input int done_dly);
    int guard = 0;
    while (!e_upd_o && guard < 200) begin
      vsync_i = ~vsync_i; flap_i = flap; step(); guard++;
    end
    flap_i = 1'b0;
    check("upd_entry", e_upd_o, 1);
    for (int i = 0; i < done_dly; i++) begin vsync_i = ~vsync_i; step(); end
    upd_done_i = 1'b1; collision_i = collide; step();
    upd_done_i = 1'b0; step();
    collision_i = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    #1 rst_ni = 1'b0;
    step(2);
    check("rst_e_inp", e_inp_o, 0);
    check("rst_running", running_o, 0);
    check("rst_score", score_o, 0);
    rst_ni = 1'b1;
    step();
    check("idle_e_inp", e_inp_o, 1);

    // 1: start, two frames, 4-cycle sampler window
    pulse_start();
    check("start_running", running_o, 1);
    vsync_edge();
    check("one_frame_wait", e_inp_o, 0);
    vsync_edge();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin cnt += e_inp_o; step(); end
    // 2: flap during LATCH
    check("latch_e_inp", e_inp_o, 0);
    flap_i = 1'b1; step(); flap_i = 1'b0;
    check("upd_pulse", e_upd_o, 1);
    check("upd_flap", flap_o, 1);
    for (int i = 0; i < 2; i++) begin cnt += e_inp_o; step(); end
    check("sample_len", cnt, 4);
    check("upd_pulse_one", e_upd_o, 0);
    upd_done_i = 1'b1; step(); upd_done_i = 1'b0;
    check("check_flap", flap_o, 0);
    step();
    check("score_1", score_o, 1);
    check("score_1_flap", flap_o, 0);

    // 3: saturation
    for (int t = 0; t < 300; t++) run_tick(t[0], 1'b0, t % 4);
    check("score_sat", score_o, 255);
    run_tick(1'b0, 1'b0, 0);
    check("score_sat_hold", score_o, 255);

    // 4: collision, restart
    run_tick(1'b1, 1'b1, 2);
    check("over_flag", game_over_o, 1);
    check("over_running", running_o, 0);
    check("over_score", score_o, 255);
    pulse_start();
    check("restart_score", score_o, 0);
    check("restart_running", running_o, 1);

    // 5: update timeout
    begin
      int guard = 0;
      while (!e_upd_o && guard < 200) begin vsync_i = ~vsync_i; step(); guard++; end
    end
    check("to_entry", e_upd_o, 1);
    step(TIMEOUT - 1);
    check("to_not_yet", timeout_err_o, 0);
    step();
    check("to_flag", timeout_err_o, 1);
    check("to_over", game_over_o, 1);
    pulse_start();
    check("to_sticky", timeout_err_o, 1);
    check("to_restart_run", running_o, 1);

    // sampler timeout: acknowledge never comes
    d_follow = 1'b0;
    for (int i = 0; i < 40; i++) begin vsync_i = ~vsync_i; step(); end
    check("samp_to_over", game_over_o, 1);
    d_follow = 1'b1;
    pulse_start();

    // 6: edges dropped during UPDATE, then reset mid-SAMPLE
    run_tick(1'b1, 1'b0, 5);
    vsync_edge();
    check("drop_wait", e_inp_o, 0);
    vsync_edge();
    check("drop_sample", e_inp_o, 1);
    step();
    #2 rst_ni = 1'b0;
    #1;
    check("async_outputs", {e_inp_o, e_upd_o, flap_o, running_o, game_over_o, timeout_err_o, score_o}, 0);
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_idle", e_inp_o, 1);
    check("post_rst_terr", timeout_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
